brick_wall_ctrl: RTL and testbench

BRICK_WALL_CTRL -- requirements
Module: brick_wall_ctrl

---
 rtl/brick_pkg.sv | 20 ++
 rtl/rr_arb2.sv | 34 +++
 rtl/brick_wall_ctrl.sv | 163 ++++++++++++++++
 tb/tb_brick_wall_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/brick_pkg.sv
// Shared definitions for the brick wall controller: grid defaults, the
// controller state type and the default level pattern.
// Optional feature macro used elsewhere: BRICK_HIT_COUNT_EN.
package brick_pkg;

    localparam int GRID_W_DEF  = 13;
    localparam int GRID_H_DEF  = 13;
    localparam int TILE_PX_DEF = 36;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Default level: a brick in every odd column, except along row 6.
    function automatic logic default_brick(input int unsigned col, input int unsigned row);
        return (col % 2 == 1) && (row != 6);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. A lone requester is always granted;
// under contention the requester that did not win last time gets the grant.
// The pointer favours requester 0 out of reset.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    logic favour_1;

    // Grant selection: pass a lone request, break ties with the pointer.
    // NOTE: grant gets a default before the if, so no path leaves it unassigned (no latch).
    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = favour_1 ? 2'b10 : 2'b01;
        end
    end

    // Pointer moves away from whichever requester just transferred.
    // NOTE: state flops use <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            favour_1 <= 1'b0;
        end else if (grant[0]) begin
            favour_1 <= 1'b1;
        end else if (grant[1]) begin
            favour_1 <= 1'b0;
        end
    end

endmodule

// File: rtl/brick_wall_ctrl.sv
// Brick wall controller: alive-bit map of GRID_W x GRID_H tiles, filled with
// the default pattern in INIT, then served to the renderer (1-cycle brick_on)
// and to two destroy requesters through a round-robin arbiter.
// Define BRICK_HIT_COUNT_EN to add the saturating destroyed_count output.
module brick_wall_ctrl
    import brick_pkg::*;
#(
    parameter int GRID_W  = GRID_W_DEF,
    parameter int GRID_H  = GRID_H_DEF,
    parameter int TILE_PX = TILE_PX_DEF
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic       brick_on,
    input  logic [1:0] req_valid,
    input  logic [7:0] req_col,
    input  logic [7:0] req_row,
    output logic [1:0] req_ready,
    output logic [1:0] hit,
    input  logic       level_load,
    output logic       busy
`ifdef BRICK_HIT_COUNT_EN
    ,
    output logic [7:0] destroyed_count
`endif
);

    localparam int CELLS  = GRID_W * GRID_H;
    localparam int ADDR_W = ($clog2(CELLS) > 8) ? $clog2(CELLS) : 8;
    localparam int PIX_W  = GRID_W * TILE_PX;
    localparam int PIX_H  = GRID_H * TILE_PX;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] init_addr, init_addr_nxt;
    logic [ADDR_W-1:0] init_col, init_col_nxt;
    logic [ADDR_W-1:0] init_row, init_row_nxt;
    logic              init_we;
    logic              run;
    logic [CELLS-1:0]  alive;
    logic [1:0]        grant;
    logic [1:0]        xfer;
    logic [1:0]        dest_ok;
    logic [ADDR_W-1:0] dest_addr [2];
    logic              px_ok;
    logic [ADDR_W-1:0] px_addr;

    assign run  = (state == RUN);
    assign busy = (state == INIT);

    // Requests are only offered to the arbiter once the map is valid.
    rr_arb2 u_arb (
        .clk   (vga_clk),
        .rst_n (reset_n),
        .valid (req_valid & {2{run}}),
        .grant (grant)
    );

    assign req_ready = grant;
    assign xfer      = req_valid & grant;

    // State register and INIT sweep position.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= INIT;
            init_addr <= '0;
            init_col  <= '0;
            init_row  <= '0;
        end else begin
            state     <= state_nxt;
            init_addr <= init_addr_nxt;
            init_col  <= init_col_nxt;
            init_row  <= init_row_nxt;
        end
    end

    // Next state: level_load restarts the sweep from any state; INIT writes
    // one entry per cycle and hands over to RUN after the last address.
    always_comb begin
        state_nxt     = state;
        init_addr_nxt = init_addr;
        init_col_nxt  = init_col;
        init_row_nxt  = init_row;
        init_we       = 1'b0;
        if (level_load) begin
            state_nxt     = INIT;
            init_addr_nxt = '0;
            init_col_nxt  = '0;
            init_row_nxt  = '0;
        end else if (state == INIT) begin
            init_we = 1'b1;
            if (init_addr == ADDR_W'(CELLS - 1)) begin
                state_nxt = RUN;
            end else begin
                init_addr_nxt = init_addr + ADDR_W'(1);
                if (init_col == ADDR_W'(GRID_W - 1)) begin
                    init_col_nxt = '0;
                    init_row_nxt = init_row + ADDR_W'(1);
                end else begin
                    init_col_nxt = init_col + ADDR_W'(1);
                end
            end
        end
    end

    // Destroy requests: range check and row-major map address per requester.
    always_comb begin
        dest_ok = '0;
        for (int i = 0; i < 2; i++) begin
            dest_ok[i]   = (32'(req_col[4*i +: 4]) < GRID_W) &&
                           (32'(req_row[4*i +: 4]) < GRID_H);
            dest_addr[i] = ADDR_W'(32'(req_row[4*i +: 4]) * GRID_W + 32'(req_col[4*i +: 4]));
        end
    end

    // Render query: pixel to tile address, valid only inside the wall area.
    always_comb begin
        px_ok   = (32'(DrawX) < PIX_W) && (32'(DrawY) < PIX_H);
        px_addr = ADDR_W'((32'(DrawY) / TILE_PX) * GRID_W + 32'(DrawX) / TILE_PX);
    end

    // Alive map: INIT fills it, accepted in-range destroys clear one bit.
    // NOTE: the map has no reset; INIT rewrites every entry before RUN reads it.
    always_ff @(posedge vga_clk) begin
        if (init_we) begin
            alive[init_addr] <= default_brick(32'(init_col), 32'(init_row));
        end else if (!level_load) begin
            for (int i = 0; i < 2; i++) begin
                if (xfer[i] && dest_ok[i]) begin
                    alive[dest_addr[i]] <= 1'b0;
                end
            end
        end
    end

    // Registered outputs: render bit and hit pulse both see pre-clear map values.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            brick_on <= 1'b0;
            hit      <= '0;
        end else begin
            brick_on <= run && px_ok && alive[px_addr];
            for (int i = 0; i < 2; i++) begin
                hit[i] <= xfer[i] && !level_load && dest_ok[i] && alive[dest_addr[i]];
            end
        end
    end

`ifdef BRICK_HIT_COUNT_EN
    // Saturating hit counter, cleared whenever INIT is re-entered.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            destroyed_count <= '0;
        end else if (level_load) begin
            destroyed_count <= '0;
        end else if ((|hit) && (destroyed_count != 8'hFF)) begin
            destroyed_count <= destroyed_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_brick_wall_ctrl.sv
// Self-checking bench for brick_wall_ctrl: reset state, INIT timing, a
// hand-derived vector table, a level_load restart sequence and randomized
// traffic against a tile-level reference model.
// Define BRICK_HIT_COUNT_EN to also check destroyed_count.
module tb_brick_wall_ctrl;

    localparam int GW = 13;
    localparam int GH = 13;
    localparam int TP = 36;

    logic       vga_clk = 1'b0;
    logic       reset_n;
    logic [9:0] DrawX, DrawY;
    logic       brick_on;
    logic [1:0] req_valid;
    logic [7:0] req_col, req_row;
    logic [1:0] req_ready, hit;
    logic       level_load;
    logic       busy;
`ifdef BRICK_HIT_COUNT_EN
    logic [7:0] dcount;
`endif

    brick_wall_ctrl dut (
        .vga_clk    (vga_clk),
        .reset_n    (reset_n),
        .DrawX      (DrawX),
        .DrawY      (DrawY),
        .brick_on   (brick_on),
        .req_valid  (req_valid),
        .req_col    (req_col),
        .req_row    (req_row),
        .req_ready  (req_ready),
        .hit        (hit),
        .level_load (level_load),
        .busy       (busy)
`ifdef BRICK_HIT_COUNT_EN
        ,
        .destroyed_count (dcount)
`endif
    );

    always #5 vga_clk = ~vga_clk;

    int errors = 0;
    int checks = 0;

    // Reference model: alive bit per tile, and who won the last grant.
    bit mdl [GH][GW];
    int last_win;

    typedef struct {
        logic [1:0] valid;
        int         c0, r0, c1, r1;
        int         x, y;
        logic [1:0] ready;
        logic [1:0] hit;
        logic       brick;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic model_init();
        for (int r = 0; r < GH; r++)
            for (int c = 0; c < GW; c++)
                mdl[r][c] = (c % 2 == 1) && (r != 6);
    endtask

    task automatic drive(input logic [1:0] v, input int c0, input int r0, input int c1,
                         input int r1, input int x, input int y);
        req_valid = v;
        req_col   = {4'(c1), 4'(c0)};
        req_row   = {4'(r1), 4'(r0)};
        DrawX     = 10'(x);
        DrawY     = 10'(y);
    endtask

    initial begin
        int n;
        int bad;
        int w;
        int v, c0, r0, c1, r1, x, y, c, r;
        logic [1:0] exp_ready, exp_hit;
        logic       exp_brick;
        int         exp_count;

        // Vectors derived from the default pattern (odd columns, row 6 empty).
        tbl[0]  = '{2'b01, 1, 0,  0, 0,  36,   0,   2'b01, 2'b01, 1'b1};
        tbl[1]  = '{2'b01, 1, 0,  0, 0,  40,   10,  2'b01, 2'b00, 1'b0};
        tbl[2]  = '{2'b10, 0, 0,  3, 0,  143,  35,  2'b10, 2'b10, 1'b1};
        tbl[3]  = '{2'b11, 5, 1,  7, 1,  0,    0,   2'b01, 2'b01, 1'b0};
        tbl[4]  = '{2'b11, 9, 1,  7, 1,  396,  467, 2'b10, 2'b10, 1'b1};
        tbl[5]  = '{2'b11, 9, 1,  11, 1, 468,  0,   2'b01, 2'b01, 1'b0};
        tbl[6]  = '{2'b11, 1, 2,  11, 1, 0,    468, 2'b10, 2'b10, 1'b0};
        tbl[7]  = '{2'b10, 0, 0,  13, 2, 36,   72,  2'b10, 2'b00, 1'b1};
        tbl[8]  = '{2'b01, 2, 3,  0, 0,  180,  216, 2'b01, 2'b00, 1'b0};
        tbl[9]  = '{2'b10, 0, 0,  5, 6,  1023, 1023,2'b10, 2'b00, 1'b0};
        tbl[10] = '{2'b01, 0, 15, 0, 0,  325,  37,  2'b01, 2'b00, 1'b0};
        tbl[11] = '{2'b00, 0, 0,  0, 0,  252,  180, 2'b00, 2'b00, 1'b1};

        // Reset state, with requests offered to prove ready stays low.
        reset_n    = 1'b0;
        level_load = 1'b0;
        drive(2'b11, 1, 0, 3, 0, 36, 0);
        #23;
        check("reset.brick_on", 32'(brick_on), 0);
        check("reset.req_ready", 32'(req_ready), 0);
        check("reset.hit", 32'(hit), 0);
        check("reset.busy", 32'(busy), 1);

        // Release reset and count edges until INIT finishes.
        drive(2'b00, 0, 0, 0, 0, 36, 0);
        #4;
        reset_n = 1'b1;
        n = 0;
        while (busy && n < 400) begin
            step();
            n++;
        end
        check("init.cycles", 32'(n), 169);

        // Render of the first live and dead tiles.
        DrawX = 10'd36; DrawY = 10'd0;
        step();
        check("render.36_0", 32'(brick_on), 1);
        DrawX = 10'd0;
        step();
        check("render.0_0", 32'(brick_on), 0);

        // Vector table: ready checked before the edge, hit/brick_on after it.
        last_win = 1;
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].valid, tbl[i].c0, tbl[i].r0, tbl[i].c1, tbl[i].r1, tbl[i].x, tbl[i].y);
            #1;
            check($sformatf("tbl%0d.ready", i), 32'(req_ready), 32'(tbl[i].ready));
            if (tbl[i].ready[0]) last_win = 0;
            if (tbl[i].ready[1]) last_win = 1;
            step();
            check($sformatf("tbl%0d.hit", i), 32'(hit), 32'(tbl[i].hit));
            check($sformatf("tbl%0d.brick_on", i), 32'(brick_on), 32'(tbl[i].brick));
        end

        // level_load together with an accepted request: grant still shown, no hit.
        drive(2'b01, 7, 5, 0, 0, 36, 0);
        level_load = 1'b1;
        #1;
        check("load_req.ready", 32'(req_ready), 1);
        last_win = 0;
        step();
        level_load = 1'b0;
        req_valid  = 2'b00;
        check("load_req.hit", 32'(hit), 0);
        check("load_req.busy", 32'(busy), 1);

        // Restart INIT 50 cycles in and watch the full new sweep.
        for (int k = 0; k < 50; k++) step();
        level_load = 1'b1;
        step();
        level_load = 1'b0;
        drive(2'b11, 1, 0, 3, 0, 36, 0);
        bad = 0;
        for (int k = 0; k < 169; k++) begin
            #1;
            if (busy !== 1'b1 || req_ready !== 2'b00 || brick_on !== 1'b0) bad++;
            step();
        end
        req_valid = 2'b00;
        check("reload.init_violations", 32'(bad), 0);
        check("reload.busy_falls", 32'(busy), 0);
`ifdef BRICK_HIT_COUNT_EN
        check("reload.count_cleared", 32'(dcount), 0);
`endif

        // Randomized traffic against the tile model.
        model_init();
        exp_count = 0;
        for (int t = 0; t < 400; t++) begin
            v  = int'($urandom_range(0, 3));
            c0 = int'($urandom_range(0, 14));
            r0 = int'($urandom_range(0, 14));
            c1 = int'($urandom_range(0, 14));
            r1 = int'($urandom_range(0, 14));
            x  = int'($urandom_range(0, 540));
            y  = int'($urandom_range(0, 540));
            drive(2'(v), c0, r0, c1, r1, x, y);
            #1;
            if (v == 3)      w = (last_win == 0) ? 1 : 0;
            else if (v == 1) w = 0;
            else if (v == 2) w = 1;
            else             w = -1;
            exp_ready = (w < 0) ? 2'b00 : 2'(1 << w);
            exp_brick = (x < GW * TP && y < GH * TP) ? mdl[y / TP][x / TP] : 1'b0;
            exp_hit   = 2'b00;
            if (w >= 0) begin
                c = (w == 0) ? c0 : c1;
                r = (w == 0) ? r0 : r1;
                if (c < GW && r < GH) begin
                    exp_hit[w] = mdl[r][c];
                    mdl[r][c]  = 1'b0;
                end
                last_win = w;
            end
            if (exp_hit != 2'b00) exp_count++;
            check($sformatf("rand%0d.ready", t), 32'(req_ready), 32'(exp_ready));
            step();
            check($sformatf("rand%0d.hit", t), 32'(hit), 32'(exp_hit));
            check($sformatf("rand%0d.brick_on", t), 32'(brick_on), 32'(exp_brick));
        end
        req_valid = 2'b00;
        step();
`ifdef BRICK_HIT_COUNT_EN
        check("count.after_random", 32'(dcount), 32'((exp_count > 255) ? 255 : exp_count));
        level_load = 1'b1;
        step();
        level_load = 1'b0;
        check("count.after_load", 32'(dcount), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
